pipe_mux_arb: RTL and testbench

PIPE_MUX_ARB -- requirements
Module: pipe_mux_arb

---
 rtl/pipe_mux_arb_if.sv | 37 +++
 rtl/pipe_mux_arb.sv | 90 +++++++++
 tb/tb_pipe_mux_arb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_mux_arb_if.sv
// Purpose: bundles the channel-side and output-side handshake of pipe_mux_arb.
//   in_data   packed per-channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  per-channel valid
//   in_ready  per-channel ready (combinational from the arbiter)
//   mode      0 = fixed select by s, 1 = round-robin
//   s         channel select used in fixed mode
//   out_data  registered selected word
//   out_valid out_data/out_ch hold an untaken word
//   out_ready downstream accept
//   out_ch    channel that supplied out_data
// slave: arbiter side, master: producer/consumer side.
interface pipe_mux_arb_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SW    = 2
);
    localparam int unsigned CH = 2 ** SW;

    logic [CH*WIDTH-1:0] in_data;
    logic [CH-1:0]       in_valid;
    logic [CH-1:0]       in_ready;
    logic                mode;
    logic [SW-1:0]       s;
    logic [WIDTH-1:0]    out_data;
    logic                out_valid;
    logic                out_ready;
    logic [SW-1:0]       out_ch;

    modport slave (
        input  in_data, in_valid, mode, s, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

    modport master (
        output in_data, in_valid, mode, s, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/pipe_mux_arb.sv
// Purpose: N-channel to 1 mux with fixed-select or round-robin grant and a
// single registered output stage that supports full throughput.
// Ports:
//   clk   rising-edge clock
//   clrn  asynchronous active-low reset
//   bus   pipe_mux_arb_if.slave (channel inputs, readies, mode/select, output)
module pipe_mux_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SW    = 2
) (
    input  logic           clk,
    input  logic           clrn,
    pipe_mux_arb_if.slave  bus
);
    localparam int unsigned CH = 2 ** SW;

    logic [WIDTH-1:0] w_ch_data [CH];
    logic             w_grant_vld;
    logic [SW-1:0]    w_grant_idx;
    logic             w_accept;
    logic             w_xfer;
    logic [CH-1:0]    w_in_ready;

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SW-1:0]    r_out_ch;
    logic [SW-1:0]    r_ptr;

    // Unpack channel data for indexed selection.
    for (genvar g = 0; g < CH; g++) begin : g_unpack
        assign w_ch_data[g] = bus.in_data[g*WIDTH +: WIDTH];
    end

    // Grant evaluation: fixed select, or first valid channel after ptr.
    // The last candidate wraps back to ptr itself so a lone ptr channel is re-granted.
    always_comb begin
        logic [SW-1:0] cand;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        cand        = '0;
        if (!bus.mode) begin
            w_grant_vld = bus.in_valid[bus.s];
            w_grant_idx = bus.s;
        end else begin
            for (int unsigned k = 1; k <= CH; k++) begin
                cand = r_ptr + SW'(k);
                if (!w_grant_vld && bus.in_valid[cand]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = cand;
                end
            end
        end
    end

    // Output stage can take a word when empty or being drained this cycle.
    assign w_accept = !r_out_valid || bus.out_ready;

    // Reset term keeps every ready low while clrn is asserted.
    assign w_xfer = w_accept && w_grant_vld && clrn;

    // One-hot ready to the granted channel only.
    always_comb begin
        w_in_ready = '0;
        if (w_xfer) begin
            w_in_ready[w_grant_idx] = 1'b1;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_ptr       <= SW'(CH - 1);
        end else if (w_xfer) begin
            r_out_data  <= w_ch_data[w_grant_idx];
            r_out_valid <= 1'b1;
            r_out_ch    <= w_grant_idx;
            r_ptr       <= w_grant_idx;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
endmodule

// File: tb/tb_pipe_mux_arb.sv
// Purpose: directed self-checking bench for pipe_mux_arb (WIDTH=32, SW=2).
// Inputs change just after the falling edge; registered outputs are checked
// one falling edge after the rising edge that loads them.
module tb_pipe_mux_arb;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned SW    = 2;
    localparam int unsigned CH    = 4;

    logic clk;
    logic clrn;
    int   total;
    int   bad;

    pipe_mux_arb_if #(.WIDTH(WIDTH), .SW(SW)) bus ();

    pipe_mux_arb #(.WIDTH(WIDTH), .SW(SW)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int i = 0; i < CH; i++) begin
            bus.in_data[i*WIDTH +: WIDTH] = base | 32'(i);
        end
    endtask

    task automatic test_reset();
        clrn          = 1'b0;
        bus.mode      = 1'b1;
        bus.s         = 2'd0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        set_data(32'hA000_0000);
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        total++;
        if (bus.out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
        total++;
        if (bus.out_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", bus.out_ch); end
        total++;
        if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", bus.in_ready); end
        tick();
        tick();
    endtask

    task automatic test_fixed();
        clrn         = 1'b1;
        bus.mode     = 1'b0;
        bus.s        = 2'd1;
        bus.in_valid = 4'b1101;
        #1;
        total++;
        if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL fixed_nogrant_ready got=%b exp=0000", bus.in_ready); end
        tick();
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fixed_nogrant_valid got=%b exp=0", bus.out_valid); end
        bus.s        = 2'd2;
        bus.in_valid = 4'b1111;
        #1;
        total++;
        if (bus.in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_ready got=%b exp=0100", bus.in_ready); end
        tick();
        total++;
        if (bus.out_data !== 32'hA000_0002) begin bad++; $display("FAIL fixed_data got=%h exp=a0000002", bus.out_data); end
        total++;
        if (bus.out_ch !== 2'd2) begin bad++; $display("FAIL fixed_ch got=%0d exp=2", bus.out_ch); end
        total++;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL fixed_valid got=%b exp=1", bus.out_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ch;
        logic [3:0]  exp_rdy;
        logic [31:0] exp_data;
        clrn = 1'b0;
        tick();
        clrn          = 1'b1;
        bus.mode      = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_ch   = 2'(i % 4);
            exp_rdy  = 4'b0001 << exp_ch;
            exp_data = 32'hA000_0000 | 32'(exp_ch);
            #1;
            total++;
            if (bus.in_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, bus.in_ready, exp_rdy); end
            tick();
            total++;
            if (bus.out_ch !== exp_ch || bus.out_valid !== 1'b1 || bus.out_data !== exp_data) begin
                bad++;
                $display("FAIL rr_out[%0d] got ch=%0d v=%b d=%h exp ch=%0d v=1 d=%h", i, bus.out_ch, bus.out_valid, bus.out_data, exp_ch, exp_data);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mode     = 1'(i % 2);
            bus.s        = 2'(i + 1);
            bus.in_valid = 4'(4'b0110 ^ i);
            set_data(32'hB000_0000 + 32'(i << 4));
            #1;
            total++;
            if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, bus.in_ready); end
            tick();
            total++;
            if (bus.out_data !== 32'hA000_0000 || bus.out_ch !== 2'd0 || bus.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold[%0d] got d=%h ch=%0d v=%b exp d=a0000000 ch=0 v=1", i, bus.out_data, bus.out_ch, bus.out_valid);
            end
        end
        bus.out_ready = 1'b1;
        bus.mode      = 1'b1;
        bus.in_valid  = 4'b1111;
        set_data(32'hA000_0000);
        #1;
        total++;
        if (bus.in_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", bus.in_ready); end
        tick();
        total++;
        if (bus.out_data !== 32'hA000_0001 || bus.out_ch !== 2'd1) begin
            bad++;
            $display("FAIL bp_release_out got d=%h ch=%0d exp d=a0000001 ch=1", bus.out_data, bus.out_ch);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] vld_seq [4] = '{4'b1000, 4'b1000, 4'b0101, 4'b0101};
        logic [3:0] rdy_seq [4] = '{4'b1000, 4'b1000, 4'b0001, 4'b0100};
        logic [1:0] ch_seq  [4] = '{2'd3, 2'd3, 2'd0, 2'd2};
        bus.mode      = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = vld_seq[i];
            #1;
            total++;
            if (bus.in_ready !== rdy_seq[i]) begin bad++; $display("FAIL wrap_ready[%0d] got=%b exp=%b", i, bus.in_ready, rdy_seq[i]); end
            tick();
            total++;
            if (bus.out_ch !== ch_seq[i] || bus.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL wrap_ch[%0d] got ch=%0d v=%b exp ch=%0d v=1", i, bus.out_ch, bus.out_valid, ch_seq[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0110;
        #2;
        clrn = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_ch !== 2'd0) begin
            bad++;
            $display("FAIL areset_out got v=%b d=%h ch=%0d exp v=0 d=0 ch=0", bus.out_valid, bus.out_data, bus.out_ch);
        end
        total++;
        if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL areset_ready got=%b exp=0000", bus.in_ready); end
        tick();
        clrn          = 1'b1;
        bus.mode      = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 4'b0010) begin bad++; $display("FAIL areset_first_ready got=%b exp=0010", bus.in_ready); end
        tick();
        total++;
        if (bus.out_ch !== 2'd1 || bus.out_data !== 32'hA000_0001) begin
            bad++;
            $display("FAIL areset_first_out got ch=%0d d=%h exp ch=1 d=a0000001", bus.out_ch, bus.out_data);
        end
    endtask

    task automatic test_idle();
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready[%0d] got=%b exp=0000", i, bus.in_ready); end
            tick();
            total++;
            if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid[%0d] got=%b exp=0", i, bus.out_valid); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
